// File: rtl/mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_arbiter_pkg
// Shared definitions for the data-memory arbiter:
//   - FSM state encodings (ST_IDLE=0, ST_ACCESS=1, ST_RESP=2)
//   - default CORE_COUNT / ADDR_W / WIDTH
//   - latency counter load helper
// Optional feature macro used by the importing files: MEM_ARB_ROUND_ROBIN_EN
// -----------------------------------------------------------------------------
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam int DEF_WIDTH      = 32;
  localparam int DEF_CORE_COUNT = 4;
  localparam int DEF_ADDR_W     = 16;
  localparam int LAT_CNT_W      = 2;

  // Down-counter load value: ACCESS lasts read_latency cycles, the last one
  // being the cycle in which the counter reads zero.
  function automatic logic [LAT_CNT_W-1:0] lat_load(input int read_latency);
    return LAT_CNT_W'(read_latency - 1);
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_grant.sv
// -----------------------------------------------------------------------------
// rr_grant
// Combinational grant picker for mem_arbiter.
// Ports:
//   request      in   CORE_COUNT  per-core request vector
//   pointer      in   IDX_W       last granted index (only with MEM_ARB_ROUND_ROBIN_EN)
//   grant_idx    out  IDX_W       chosen core
//   grant_valid  out  1           any request present
// MEM_ARB_ROUND_ROBIN_EN defined   : search starts at pointer+1, wrapping.
// MEM_ARB_ROUND_ROBIN_EN undefined : fixed priority, lowest index wins.
// -----------------------------------------------------------------------------
module rr_grant
  import mem_arbiter_pkg::*;
#(
  parameter int CORE_COUNT = DEF_CORE_COUNT,
  parameter int IDX_W      = $clog2(DEF_CORE_COUNT)
) (
  input  logic [CORE_COUNT-1:0] request,
`ifdef MEM_ARB_ROUND_ROBIN_EN
  input  logic [IDX_W-1:0]      pointer,
`endif
  output logic [IDX_W-1:0]      grant_idx,
  output logic                  grant_valid
);

  assign grant_valid = |request;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // Requesters strictly above the pointer take precedence; if none exist the
  // search wraps around to the lowest requesting index.
  logic [CORE_COUNT-1:0] above_ptr;

  generate
    for (genvar gi = 0; gi < CORE_COUNT; gi++) begin : g_above
      assign above_ptr[gi] = request[gi] & (IDX_W'(gi) > pointer);
    end
  endgenerate

  always_comb begin
    grant_idx = '0;
    for (int i = CORE_COUNT - 1; i >= 0; i--) begin
      if (request[i]) grant_idx = IDX_W'(i);
    end
    for (int i = CORE_COUNT - 1; i >= 0; i--) begin
      if (above_ptr[i]) grant_idx = IDX_W'(i);
    end
  end
`else
  always_comb begin
    grant_idx = '0;
    for (int i = CORE_COUNT - 1; i >= 0; i--) begin
      if (request[i]) grant_idx = IDX_W'(i);
    end
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares one single-port RAM between CORE_COUNT cores. One transaction at a
// time: IDLE (grant + register RAM controls) -> ACCESS (write 1 cycle, read
// READ_LATENCY cycles) -> RESP (one-cycle response pulse) -> IDLE.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   core_request     per-core level request, held until response
//   core_wren        per-core 1=write / 0=read
//   core_address     flattened per-core address, core i at [i*WIDTH +: WIDTH]
//   core_writedata   flattened per-core write data
//   core_response    one-cycle completion pulse to the granted core
//   core_readdata    broadcast read data, valid during the response pulse
//   ram_address      RAM address (low ADDR_W bits of the core address)
//   ram_writedata    RAM write data
//   ram_wren         RAM write strobe, high for the single write ACCESS cycle
//   ram_readdata     RAM read data, sampled READ_LATENCY edges after
//                    ram_address is presented
//   busy             high whenever the FSM is not in IDLE
// Macro MEM_ARB_ROUND_ROBIN_EN selects round-robin arbitration; otherwise
// fixed priority (lowest index wins).
// -----------------------------------------------------------------------------
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int WIDTH        = DEF_WIDTH,
  parameter int CORE_COUNT   = DEF_CORE_COUNT,
  parameter int IDX_W        = $clog2(DEF_CORE_COUNT),
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int READ_LATENCY = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [CORE_COUNT-1:0]       core_request,
  input  logic [CORE_COUNT-1:0]       core_wren,
  input  logic [CORE_COUNT*WIDTH-1:0] core_address,
  input  logic [CORE_COUNT*WIDTH-1:0] core_writedata,
  output logic [CORE_COUNT-1:0]       core_response,
  output logic [WIDTH-1:0]            core_readdata,
  output logic [ADDR_W-1:0]           ram_address,
  output logic [WIDTH-1:0]            ram_writedata,
  output logic                        ram_wren,
  input  logic [WIDTH-1:0]            ram_readdata,
  output logic                        busy
);

  state_t                 state_reg, state_next;
  logic [IDX_W-1:0]       gnt_reg;
  logic [LAT_CNT_W-1:0]   lat_cnt_reg;
  logic [ADDR_W-1:0]      ram_address_reg;
  logic [WIDTH-1:0]       ram_writedata_reg;
  logic                   ram_wren_reg;
  logic [WIDTH-1:0]       core_readdata_reg;
  logic [CORE_COUNT-1:0]  core_response_reg;

  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_valid;
  logic                   access_done;

  // Per-core views of the flattened buses. Only the low ADDR_W address bits
  // reach the RAM, so accesses wrap modulo 2^ADDR_W.
  logic [ADDR_W-1:0]      addr_lo   [CORE_COUNT];
  logic [WIDTH-1:0]       wdata_arr [CORE_COUNT];
  logic [CORE_COUNT*(WIDTH-ADDR_W)-1:0] unused_addr_hi;

  generate
    for (genvar gi = 0; gi < CORE_COUNT; gi++) begin : g_unpack
      assign addr_lo[gi]   = core_address[gi*WIDTH +: ADDR_W];
      assign wdata_arr[gi] = core_writedata[gi*WIDTH +: WIDTH];
      assign unused_addr_hi[gi*(WIDTH-ADDR_W) +: (WIDTH-ADDR_W)] =
        core_address[gi*WIDTH + ADDR_W +: (WIDTH-ADDR_W)];
    end
  endgenerate

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic [IDX_W-1:0] ptr_reg;
`endif

  rr_grant #(
    .CORE_COUNT (CORE_COUNT),
    .IDX_W      (IDX_W)
  ) u_rr_grant (
    .request     (core_request),
`ifdef MEM_ARB_ROUND_ROBIN_EN
    .pointer     (ptr_reg),
`endif
    .grant_idx   (pick_idx),
    .grant_valid (pick_valid)
  );

  // ram_wren_reg is high for the whole (single-cycle) write ACCESS, so it
  // doubles as the "this transaction is a write" flag.
  assign access_done = ram_wren_reg || (lat_cnt_reg == '0);

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:   if (pick_valid) state_next = ST_ACCESS;
      ST_ACCESS: if (access_done) state_next = ST_RESP;
      ST_RESP:   state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_reg           <= '0;
      lat_cnt_reg       <= '0;
      ram_address_reg   <= '0;
      ram_writedata_reg <= '0;
      ram_wren_reg      <= 1'b0;
      core_readdata_reg <= '0;
      core_response_reg <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      ptr_reg           <= IDX_W'(CORE_COUNT - 1);
`endif
    end else begin
      core_response_reg <= '0;
      case (state_reg)
        ST_IDLE: begin
          if (pick_valid) begin
            gnt_reg           <= pick_idx;
            ram_address_reg   <= addr_lo[pick_idx];
            ram_writedata_reg <= wdata_arr[pick_idx];
            ram_wren_reg      <= core_wren[pick_idx];
            lat_cnt_reg       <= lat_load(READ_LATENCY);
`ifdef MEM_ARB_ROUND_ROBIN_EN
            ptr_reg           <= pick_idx;
`endif
          end
        end
        ST_ACCESS: begin
          if (access_done) begin
            ram_wren_reg               <= 1'b0;
            core_response_reg[gnt_reg] <= 1'b1;
            if (!ram_wren_reg) core_readdata_reg <= ram_readdata;
          end else begin
            lat_cnt_reg <= lat_cnt_reg - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign core_response = core_response_reg;
  assign core_readdata = core_readdata_reg;
  assign ram_address   = ram_address_reg;
  assign ram_writedata = ram_writedata_reg;
  assign ram_wren      = ram_wren_reg;
  assign busy          = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Directed bench for mem_arbiter. Three instances share the core data buses:
// dut (READ_LATENCY=1) carries most traffic; d2/d3 (READ_LATENCY=2/3) have
// their own request vectors for the latency sweep. Each instance has its own
// RAM model whose read path has READ_LATENCY-1 output registers.
// Honors MEM_ARB_ROUND_ROBIN_EN for the expected contention order.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int W  = 32;
  localparam int CC = 4;
  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [CC-1:0] core_request = '0;
  logic [CC-1:0] sw2_request = '0;
  logic [CC-1:0] sw3_request = '0;
  logic [CC-1:0] core_wren = '0;
  logic [CC*W-1:0] core_address = '0;
  logic [CC*W-1:0] core_writedata = '0;

  logic [CC-1:0] core_response, d2_core_response, d3_core_response;
  logic [W-1:0]  core_readdata, d2_core_readdata, d3_core_readdata;
  logic [AW-1:0] ram_address, d2_ram_address, d3_ram_address;
  logic [W-1:0]  ram_writedata, d2_ram_writedata, d3_ram_writedata;
  logic          ram_wren, d2_ram_wren, d3_ram_wren;
  logic [W-1:0]  ram_readdata, d2_ram_readdata, d3_ram_readdata;
  logic          busy, d2_busy, d3_busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.WIDTH(W), .CORE_COUNT(CC), .IDX_W(2), .ADDR_W(AW), .READ_LATENCY(1)) dut (
    .clk(clk), .rst_n(rst_n), .core_request(core_request), .core_wren(core_wren),
    .core_address(core_address), .core_writedata(core_writedata),
    .core_response(core_response), .core_readdata(core_readdata),
    .ram_address(ram_address), .ram_writedata(ram_writedata), .ram_wren(ram_wren),
    .ram_readdata(ram_readdata), .busy(busy));

  mem_arbiter #(.WIDTH(W), .CORE_COUNT(CC), .IDX_W(2), .ADDR_W(AW), .READ_LATENCY(2)) d2 (
    .clk(clk), .rst_n(rst_n), .core_request(sw2_request), .core_wren(core_wren),
    .core_address(core_address), .core_writedata(core_writedata),
    .core_response(d2_core_response), .core_readdata(d2_core_readdata),
    .ram_address(d2_ram_address), .ram_writedata(d2_ram_writedata), .ram_wren(d2_ram_wren),
    .ram_readdata(d2_ram_readdata), .busy(d2_busy));

  mem_arbiter #(.WIDTH(W), .CORE_COUNT(CC), .IDX_W(2), .ADDR_W(AW), .READ_LATENCY(3)) d3 (
    .clk(clk), .rst_n(rst_n), .core_request(sw3_request), .core_wren(core_wren),
    .core_address(core_address), .core_writedata(core_writedata),
    .core_response(d3_core_response), .core_readdata(d3_core_readdata),
    .ram_address(d3_ram_address), .ram_writedata(d3_ram_writedata), .ram_wren(d3_ram_wren),
    .ram_readdata(d3_ram_readdata), .busy(d3_busy));

  // ---------------- RAM models ----------------
  logic [W-1:0]  mem1 [0:65535];
  logic [W-1:0]  mem2 [0:65535];
  logic [W-1:0]  mem3 [0:65535];
  logic          pre_we = 1'b0;
  logic [2:0]    pre_mask = '0;
  logic [AW-1:0] pre_addr = '0;
  logic [W-1:0]  pre_data = '0;
  logic [W-1:0]  p2_q, p3_q1, p3_q2;

  always @(posedge clk) begin
    if (ram_wren)    mem1[ram_address]    <= ram_writedata;
    if (d2_ram_wren) mem2[d2_ram_address] <= d2_ram_writedata;
    if (d3_ram_wren) mem3[d3_ram_address] <= d3_ram_writedata;
    if (pre_we && pre_mask[0]) mem1[pre_addr] <= pre_data;
    if (pre_we && pre_mask[1]) mem2[pre_addr] <= pre_data;
    if (pre_we && pre_mask[2]) mem3[pre_addr] <= pre_data;
    p2_q  <= mem2[d2_ram_address];
    p3_q1 <= mem3[d3_ram_address];
    p3_q2 <= p3_q1;
  end

  assign ram_readdata    = mem1[ram_address];
  assign d2_ram_readdata = p2_q;
  assign d3_ram_readdata = p3_q2;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  int exp_order [6] = '{0, 1, 2, 3, 0, 0};
`else
  int exp_order [6] = '{0, 1, 0, 2, 0, 3};
`endif

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [2:0] mask, input logic [AW-1:0] a, input logic [W-1:0] d);
    pre_mask = mask; pre_addr = a; pre_data = d; pre_we = 1'b1;
    @(posedge clk); #1;
    pre_we = 1'b0;
  endtask

  task automatic set_core(input int c, input logic wr, input logic [W-1:0] a, input logic [W-1:0] d);
    core_wren[c] = wr;
    core_address[c*W +: W] = a;
    core_writedata[c*W +: W] = d;
  endtask

  // Called 1ns after a rising edge with dut idle; that cycle is the grant cycle.
  task automatic run_txn(input string tag, input int c, input logic wr,
                         input logic [W-1:0] a, input logic [W-1:0] d,
                         input int exp_lat, input logic [W-1:0] exp_rd);
    int lat;
    logic [31:0] exp_oh;
    exp_oh = 32'(1) << c;
    set_core(c, wr, a, d);
    core_request[c] = 1'b1;
    lat = -1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (k == 1) begin
        check({tag, "_ram_address"}, 32'(ram_address), 32'(a[AW-1:0]));
        check({tag, "_ram_wren"}, 32'(ram_wren), 32'(wr));
        if (wr) check({tag, "_ram_writedata"}, ram_writedata, d);
      end
      if (core_response != '0) begin
        lat = k;
        break;
      end
    end
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_response"}, 32'(core_response), exp_oh);
    check({tag, "_wren_clear"}, 32'(ram_wren), 32'd0);
    if (!wr) check({tag, "_readdata"}, core_readdata, exp_rd);
    $display("txn %s core=%0d wr=%0d addr=0x%08h lat=%0d rdata=0x%08h",
             tag, c, wr, a, lat, core_readdata);
    @(posedge clk); #1;
    core_request[c] = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int order [$];
    int rereq_left;
    bit raise0_pending;
    logic [CC-1:0] resp_snap;
    logic [W-1:0]  rd_snap;
    int idx, lat2, lat3;

    // Reset state
    repeat (2) @(negedge clk);
    check("reset_response", 32'(core_response), 32'd0);
    check("reset_readdata", core_readdata, 32'd0);
    check("reset_ram_address", 32'(ram_address), 32'd0);
    check("reset_ram_writedata", ram_writedata, 32'd0);
    check("reset_ram_wren", 32'(ram_wren), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);

    @(posedge clk); #1;
    preload(3'b001, 16'h0010, 32'hDEAD_BEEF);
    preload(3'b001, 16'h0004, 32'hCAFE_0004);
    for (int i = 0; i < CC; i++) preload(3'b001, AW'(16'h0020 + i), 32'hA000_0000 + i);
    preload(3'b010, 16'h0030, 32'h2222_2222);
    preload(3'b100, 16'h0030, 32'h3333_3333);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single read, single write, unchanged readdata after write, read-back
    run_txn("read_c1", 1, 1'b0, 32'h0000_0010, 32'h0, 2, 32'hDEAD_BEEF);
    run_txn("write_c2", 2, 1'b1, 32'h0000_00FF, 32'h1234_5678, 2, 32'h0);
    check("readdata_kept_after_write", core_readdata, 32'hDEAD_BEEF);
    run_txn("readback_c2", 2, 1'b0, 32'h0000_00FF, 32'h0, 2, 32'h1234_5678);

    // Address wrap: upper address bits ignored
    run_txn("wrap_c3", 3, 1'b0, 32'h0001_0004, 32'h0, 2, 32'hCAFE_0004);

    // Idle after response: no second service of a completed request
    @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_response", 32'(core_response), 32'd0);
    @(posedge clk); #1;

    // Contention: all four request; core 0 re-requests twice
    for (int i = 0; i < CC; i++) set_core(i, 1'b0, 32'h0000_0020 + i, 32'h0);
    core_request = 4'hF;
    rereq_left = 2;
    raise0_pending = 1'b0;
    for (int cyc = 0; cyc < 200 && order.size() < 6; cyc++) begin
      @(negedge clk);
      resp_snap = core_response;
      rd_snap = core_readdata;
      @(posedge clk); #1;
      if (raise0_pending) begin
        core_request[0] = 1'b1;
        raise0_pending = 1'b0;
      end
      if (resp_snap != '0) begin
        idx = 0;
        for (int i = 0; i < CC; i++) if (resp_snap[i]) idx = i;
        check("cont_onehot", 32'($countones(resp_snap)), 32'd1);
        check("cont_readdata", rd_snap, 32'hA000_0000 + idx);
        $display("txn contention grant=%0d rdata=0x%08h", idx, rd_snap);
        order.push_back(idx);
        core_request[idx] = 1'b0;
        if (idx == 0 && rereq_left > 0) begin
          rereq_left--;
          raise0_pending = 1'b1;
        end
      end
    end
    core_request = '0;
    check("cont_count", 32'(order.size()), 32'd6);
    for (int k = 0; k < 6; k++)
      check($sformatf("cont_order_%0d", k), 32'((k < order.size()) ? order[k] : -1), 32'(exp_order[k]));
    @(posedge clk); #1;

    // Latency sweep on READ_LATENCY=2 and 3 instances
    set_core(1, 1'b0, 32'h0000_0030, 32'h0);
    sw2_request[1] = 1'b1;
    sw3_request[1] = 1'b1;
    lat2 = -1;
    lat3 = -1;
    for (int k = 0; k < 12 && (lat2 < 0 || lat3 < 0); k++) begin
      @(negedge clk);
      if (k >= 1 && lat2 < 0 && d2_core_response == '0)
        check("rl2_addr_stable", 32'(d2_ram_address), 32'h0030);
      if (k >= 1 && lat3 < 0 && d3_core_response == '0)
        check("rl3_addr_stable", 32'(d3_ram_address), 32'h0030);
      if (lat2 < 0 && d2_core_response != '0) begin
        lat2 = k;
        check("rl2_response", 32'(d2_core_response), 32'h2);
        check("rl2_readdata", d2_core_readdata, 32'h2222_2222);
      end
      if (lat3 < 0 && d3_core_response != '0) begin
        lat3 = k;
        check("rl3_response", 32'(d3_core_response), 32'h2);
        check("rl3_readdata", d3_core_readdata, 32'h3333_3333);
      end
      @(posedge clk); #1;
      if (lat2 >= 0) sw2_request = '0;
      if (lat3 >= 0) sw3_request = '0;
    end
    check("rl2_latency", 32'(lat2), 32'd3);
    check("rl3_latency", 32'(lat3), 32'd4);
    $display("txn sweep rl2_lat=%0d rl3_lat=%0d", lat2, lat3);
    sw2_request = '0;
    sw3_request = '0;
    @(posedge clk); #1;

    // Reset during a read ACCESS
    set_core(1, 1'b0, 32'h0000_0010, 32'h0);
    core_request[1] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("midrst_busy_before", 32'(busy), 32'd1);
    check("midrst_addr_before", 32'(ram_address), 32'h0010);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_ram_address", 32'(ram_address), 32'd0);
    check("midrst_readdata", core_readdata, 32'd0);
    check("midrst_response", 32'(core_response), 32'd0);
    core_request = '0;
    repeat (2) begin
      @(negedge clk);
      check("midrst_no_pulse", 32'(core_response), 32'd0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    $display("txn reset_mid_read aborted");

    // Fresh requests after reset: core 0 wins first, then core 2
    set_core(2, 1'b0, 32'h0000_0022, 32'h0);
    core_request[2] = 1'b1;
    run_txn("postrst_c0", 0, 1'b0, 32'h0000_0020, 32'h0, 2, 32'hA000_0000);
    run_txn("postrst_c2", 2, 1'b0, 32'h0000_0022, 32'h0, 2, 32'hA000_0002);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
